// File: rtl/avr_tx_gate.sv
// avr_tx_gate
//   Serial transmit stage toward the AVR. Bytes written by user logic are
//   queued in a small FIFO and sent as 8N1 frames once the AVR reports ready
//   and its flow-control pin (tx_block) is low.
//
//   Parameters:
//     CLK_RATE  clk frequency in Hz
//     BAUD      serial bit rate (CLK_RATE/BAUD must be >= 2)
//     DEPTH     FIFO depth in bytes (power of two, >= 2)
//
//   Ports:
//     clk       clock
//     rst       synchronous active-high reset
//     ready     AVR-ready flag, synchronous to clk
//     tx_block  AVR flow-control pin, asynchronous, high = stop sending
//     data      byte to queue
//     new_data  write strobe for data
//     busy      high while writes are refused (FIFO full or AVR not ready)
//     overflow  one-cycle pulse after a refused write
//     count     FIFO occupancy
//     tx        serial line, idle high
//     tx_oe     output enable for tx (registered copy of ready)
//
//   Build option:
//     AVR_TX_GATE_FLUSH_EN  when defined, the FIFO is emptied on every cycle
//                           ready is low; otherwise queued bytes are kept and
//                           sent once ready returns.
module avr_tx_gate #(
    parameter int CLK_RATE = 50000000,
    parameter int BAUD     = 500000,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready,
    input  logic                     tx_block,
    input  logic [7:0]               data,
    input  logic                     new_data,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx,
    output logic                     tx_oe
);
    localparam int CLK_PER_BIT = CLK_RATE / BAUD;
    localparam int CNT_W       = $clog2(CLK_PER_BIT);
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CW          = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0]    FULL     = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               tx_oe_q;
    logic               ovf_q;
    logic               blk_m_q;
    logic               blk_s;

    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;

    logic               push;
    logic               pop;
    logic               start_ok;
    logic               bit_last;

    assign busy     = (count_q == FULL) | ~ready;
    assign push     = new_data & ~busy;
    assign start_ok = ready & ~blk_s & (count_q != '0);
    assign bit_last = (clk_cnt_q == BIT_LAST);

    // Two-flop synchroniser for the asynchronous flow-control pin.
    always_ff @(posedge clk) begin
        blk_m_q <= tx_block;
        blk_s   <= blk_m_q;
    end

    // FIFO storage and transmit shift register carry no reset; validity is
    // tracked by the pointers/count and the FSM state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
        shift_q <= shift_d;
    end

    // Next-state logic. tx_d is derived from the current state, so the line
    // trails the FSM by one cycle; this gives the two-cycle push-to-start-bit
    // latency and keeps back-to-back frames contiguous.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        tx_d      = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                tx_d      = 1'b0;
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (bit_last) begin
                    clk_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx_d      = shift_q[0];
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (bit_last) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                tx_d      = 1'b1;
                clk_cnt_d = clk_cnt_q + 1'b1;
                if (bit_last) begin
                    clk_cnt_d = '0;
                    // Byte boundary: flow control is only honoured here.
                    if (start_ok) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_cnt_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Losing ready aborts any frame in flight immediately.
        if (!ready) begin
            state_d   = IDLE;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            pop       = 1'b0;
            tx_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            tx_oe_q   <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            tx_oe_q   <= ready;
            ovf_q     <= new_data & busy;

            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
`ifdef AVR_TX_GATE_FLUSH_EN
            if (!ready) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_oe    = tx_oe_q;
    assign overflow = ovf_q;
    assign count    = count_q;

endmodule

// File: tb/tb_avr_tx_gate.sv
// Testbench for avr_tx_gate with CLK_PER_BIT = 4 and DEPTH = 8.
// A frame-level reference model predicts every output each cycle; a bench
// UART receiver decodes the serial line for literal byte expectations.
module tb_avr_tx_gate;
    localparam int DEPTH = 8;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ready    = 1'b0;
    logic       tx_block = 1'b0;
    logic [7:0] data     = 8'h00;
    logic       new_data = 1'b0;
    logic       busy;
    logic       overflow;
    logic [3:0] count;
    logic       tx;
    logic       tx_oe;

    avr_tx_gate #(
        .CLK_RATE (40),
        .BAUD     (10),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .tx_block (tx_block),
        .data     (data),
        .new_data (new_data),
        .busy     (busy),
        .overflow (overflow),
        .count    (count),
        .tx       (tx),
        .tx_oe    (tx_oe)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    int         msp     = -1;      // position within the current frame, -1 = none
    logic [7:0] mcur    = 8'h00;
    logic       exp_tx  = 1'b1;
    logic       exp_oe  = 1'b0;
    logic       exp_ovf = 1'b0;
    logic       mb1     = 1'b0;
    logic       mb2     = 1'b0;
    bit         chk_en  = 1'b0;

    // Line level for a frame position: start bit, 8 data bits LSB first, stop.
    function automatic logic line_bit(input logic [7:0] b, input int sp);
        int k;
        if (sp < 0) return 1'b1;
        k = sp / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    initial begin : model
        int   sz;
        logic rdy;
        forever begin
            @(posedge clk);
            sz  = mq.size();
            rdy = ready;
            if (rst) begin
                mq.delete();
                msp     = -1;
                exp_tx  = 1'b1;
                exp_oe  = 1'b0;
                exp_ovf = 1'b0;
            end else begin
                exp_oe  = rdy;
                exp_ovf = new_data && (sz == DEPTH || !rdy);
                if (!rdy) begin
                    exp_tx = 1'b1;
                    msp    = -1;
`ifdef AVR_TX_GATE_FLUSH_EN
                    mq.delete();
`endif
                end else begin
                    exp_tx = line_bit(mcur, msp);
                    if (msp == -1 || msp == FRAME - 1) begin
                        if (!mb2 && sz != 0) begin
                            mcur = mq.pop_front();
                            msp  = 0;
                        end else begin
                            msp = -1;
                        end
                    end else begin
                        msp++;
                    end
                    if (new_data && sz < DEPTH) mq.push_back(data);
                end
            end
            mb2    = mb1;
            mb1    = tx_block;
            chk_en = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("tx",       32'(tx),        32'(exp_tx));
                check("tx_oe",    32'(tx_oe),     32'(exp_oe));
                check("overflow", 32'(overflow),  32'(exp_ovf));
                check("count",    32'(count),     32'(mq.size()));
                check("busy",     32'(busy),      32'((mq.size() == DEPTH) || !ready));
            end
        end
    end

    // ---------------- serial line decoder ----------------
    logic [7:0] rxq[$];

    initial begin : rx_decode
        logic [7:0] b;
        logic       st_ok;
        forever begin
            @(posedge clk);
            #2;
            if (chk_en && !rst && tx === 1'b0) begin
                repeat (CPB / 2) @(posedge clk);
                #2;
                st_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #2;
                    b[i] = tx;
                end
                repeat (CPB) @(posedge clk);
                #2;
                if (st_ok && tx === 1'b1) rxq.push_back(b);
            end
        end
    end

    task automatic rx_expect(input string nm, input int idx, input logic [7:0] exp);
        check(nm, (idx < rxq.size()) ? 32'(rxq[idx]) : 32'hDEAD, 32'(exp));
    endtask

    task automatic push(input logic [7:0] b);
        data     = b;
        new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Not ready: idle line, pad disabled, writes refused.
        check("rst_tx",    32'(tx),    32'd1);
        check("rst_tx_oe", 32'(tx_oe), 32'd0);
        check("rst_busy",  32'(busy),  32'd1);
        push(8'h55);
        check("drop_ovf",   32'(overflow), 32'd1);
        check("drop_count", 32'(count),    32'd0);
        @(negedge clk);
        check("drop_ovf_once", 32'(overflow), 32'd0);

        // Single frame 0xA3.
        ready    = 1'b1;
        tx_block = 1'b0;
        repeat (3) @(negedge clk);
        check("rdy_tx_oe", 32'(tx_oe), 32'd1);
        check("rdy_busy",  32'(busy),  32'd0);
        rxq.delete();
        push(8'hA3);
        check("a3_count", 32'(count), 32'd1);
        @(posedge clk);
        #1;
        check("a3_tx_p1", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        check("a3_tx_p2", 32'(tx), 32'd0);
        repeat (FRAME + 5) @(negedge clk);
        check("a3_rx_n", 32'(rxq.size()), 32'd1);
        rx_expect("a3_rx", 0, 8'hA3);
        check("a3_count_end", 32'(count), 32'd0);

        // Fill while blocked, overflow on the 9th, then drain.
        tx_block = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) push(8'(i));
        check("full_ovf",   32'(overflow), 32'd1);
        check("full_count", 32'(count),    32'd8);
        check("full_busy",  32'(busy),     32'd1);
        rxq.delete();
        tx_block = 1'b0;
        repeat (8 * FRAME + 15) @(negedge clk);
        check("drain_rx_n", 32'(rxq.size()), 32'd8);
        for (int i = 0; i < 8; i++) rx_expect("drain_rx", i, 8'(i));

        // Block raised mid-frame: current byte completes, rest wait.
        rxq.delete();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (10) @(negedge clk);
        tx_block = 1'b1;
        repeat (60) @(negedge clk);
        check("blk_count", 32'(count),       32'd2);
        check("blk_tx",    32'(tx),          32'd1);
        check("blk_rx_n",  32'(rxq.size()),  32'd1);
        rx_expect("blk_rx0", 0, 8'h11);
        tx_block = 1'b0;
        repeat (2 * FRAME + 20) @(negedge clk);
        check("unblk_rx_n", 32'(rxq.size()), 32'd3);
        rx_expect("unblk_rx1", 1, 8'h22);
        rx_expect("unblk_rx2", 2, 8'h33);

        // Ready drops mid-DATA of the first of 4 bytes.
        rxq.delete();
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        push(8'hC4);
        repeat (10) @(negedge clk);
        ready = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        @(negedge clk);
`ifdef AVR_TX_GATE_FLUSH_EN
        check("abort_count", 32'(count), 32'd0);
`else
        check("abort_count", 32'(count), 32'd3);
`endif
        repeat (50) @(negedge clk);
        rxq.delete();
        ready = 1'b1;
        repeat (3 * FRAME + 20) @(negedge clk);
`ifdef AVR_TX_GATE_FLUSH_EN
        check("resume_rx_n", 32'(rxq.size()), 32'd0);
`else
        check("resume_rx_n", 32'(rxq.size()), 32'd3);
        rx_expect("resume_rx0", 0, 8'hC2);
        rx_expect("resume_rx1", 1, 8'hC3);
        rx_expect("resume_rx2", 2, 8'hC4);
`endif

        // Push and pop on the same edge with one byte queued.
        rxq.delete();
        tx_block = 1'b1;
        repeat (3) @(negedge clk);
        push(8'h5A);
        repeat (2) @(negedge clk);
        check("pp_count_pre", 32'(count), 32'd1);
        tx_block = 1'b0;
        @(negedge clk);
        @(negedge clk);
        push(8'hA5);
        check("pp_count", 32'(count), 32'd1);
        repeat (2 * FRAME + 10) @(negedge clk);
        check("pp_rx_n", 32'(rxq.size()), 32'd2);
        rx_expect("pp_rx0", 0, 8'h5A);
        rx_expect("pp_rx1", 1, 8'hA5);

        // Reset in the middle of a frame.
        push(8'h99);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_tx",    32'(tx),    32'd1);
        check("mrst_tx_oe", 32'(tx_oe), 32'd0);
        check("mrst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/avr_tx_gate.md
# avr_tx_gate

Serial transmit stage toward the AVR on the Mojo, sitting directly downstream of the AVR status monitor: it consumes that block's `ready` flag and only drives the AVR serial line once the AVR is up. User logic loads bytes through a valid/busy handshake into a small FIFO. An 8N1 UART transmitter drains the FIFO while `ready` is high and the AVR's `tx_block` flow-control pin is low.

## Interface
- `CLK_RATE`, 50000000: clk frequency in Hz.
- `BAUD`, 500000: serial bit rate; `CLK_PER_BIT = CLK_RATE/BAUD`, must be >= 2.
- `DEPTH`, 8: FIFO depth in bytes; power of two, >= 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ready`  in  1  AVR-ready flag from the status monitor; synchronous to clk.
- `tx_block`  in  1  AVR flow-control pin, high = stop sending; asynchronous.
- `data`  in  8  byte to send.
- `new_data`  in  1  write strobe for `data`.
- `busy`  out  1  high = writes are not accepted.
- `overflow`  out  1  one-cycle pulse when a write is rejected.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `tx`  out  1  serial line to the AVR, idle high.
- `tx_oe`  out  1  output enable for `tx`; low = pad high-Z.

## Operation
- Synchronise `tx_block` through two flops (`blk_s`) before any use.
- **busy:** combinational, `busy = (count == DEPTH) | ~ready`.
- **Write:** on `new_data & ~busy`, push `data`.
- **Rejected write:** on `new_data & busy`, the byte is discarded, FIFO and count are unchanged, and `overflow` is high the next cycle.
- **tx_oe:** registered copy of `ready`.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE -> START when `ready & ~blk_s & count != 0`. The head byte is popped into the shift register in that same cycle.
  - START: `tx = 0` for CLK_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLK_PER_BIT cycles each, then STOP.
  - STOP: `tx = 1` for CLK_PER_BIT cycles. On its last cycle, if the IDLE->START condition holds, the FSM pops the next byte and goes directly to START with no gap. Otherwise it goes to IDLE.
- **tx_block:** sampled only at byte boundaries. If `blk_s` rises mid-byte, the current byte completes.
- **ready falling mid-byte:** abort. The next cycle the FSM is in IDLE, `tx = 1` and the bit counter is cleared. The in-flight byte is lost.
- **Simultaneous push and pop:** the push is accepted if the FIFO was not full, the pop happens, and `count` is unchanged. A push to an empty FIFO cannot be popped in the same cycle.
- **Pointers:** wrap modulo DEPTH. `count` saturates at DEPTH by construction.

## Timing
- **Reset values:** `tx = 1`, `tx_oe = 0`, `overflow = 0`, `count = 0`, FSM IDLE, FIFO empty. `busy` follows `ready` (the status monitor holds it low during reset).
- `count` updates the cycle after a push or pop.
- **Start latency:** the IDLE->START condition is true at edge N, and `tx` falls after edge N+1. The condition can be true only from the cycle after the push, so the first start bit appears 2 cycles after the push edge.
- **Frame length:** exactly 10 x CLK_PER_BIT cycles. Back-to-back frames are contiguous.
- **tx_block latency:** 2 synchroniser cycles before it affects the FSM.
- **rst mid-frame:** every output returns to its reset value at the next edge.

## Configuration
- `AVR_TX_GATE_FLUSH_EN`:
  - **Defined:** on the cycle `ready` is sampled low, the FIFO is flushed. Pointers clear and `count = 0` the next cycle.
  - **Undefined:** FIFO contents are retained across a ready drop, and transmission resumes from the head byte once `ready` returns high.
- The abort of the in-flight byte applies in both cases.

## Test plan
All scenarios use CLK_RATE=40, BAUD=10 (CLK_PER_BIT=4) and DEPTH=8.
- Reset, then `ready=0` -> `tx=1`, `tx_oe=0`, `busy=1`. Write 0x55 while `busy=1` -> dropped, `overflow` pulses once, `count=0`.
- Set `ready=1`, `tx_block=0`, write 0xA3 -> `tx_oe=1`, `tx` low 2 cycles after the push, then bits 1,1,0,0,0,1,0,1 at 4 cycles each, stop high; total 40 cycles. `count` goes 1 -> 0.
- Write 9 bytes 0x00..0x08 while `tx_block=1` -> `count=8`, `busy=1`, 9th write raises `overflow`. Release `tx_block` -> 8 contiguous frames (320 cycles), bytes in order.
- Raise `tx_block` mid-frame of the first of 3 queued bytes -> that frame completes, `tx` stays high, `count=2`. Lower `tx_block` -> remaining 2 frames are sent.
- Queue 4 bytes and drop `ready` mid-DATA of the first -> `tx=1` next cycle.
  - FLUSH_EN defined: `count=0`, nothing is sent after `ready` returns.
  - FLUSH_EN undefined: `count=3`, bytes 2..4 are sent after `ready` returns.
- With 1 byte queued, push and pop in the same cycle (IDLE start) -> `count` stays 1, next frame carries the second byte.
